// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges core writes and a FIFO of load returns onto one registered register-file write port.
// Optional macro WB_STARVE_EN adds a starvation counter that forces a load drain after STARVE_LIMIT core grants.
module wb_arbiter #(
  parameter int LD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_wr_en,
  input  logic [4:0]  core_rd,
  input  logic [1:0]  core_sel,
  input  logic [31:0] alu_out,
  input  logic [31:0] pc_o,
  input  logic [31:0] lui_imme,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        core_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);
  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = $clog2(LD_DEPTH + 1);

  if (LD_DEPTH < 2 || (LD_DEPTH & (LD_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
    $error("wb_arbiter: LD_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic [4:0]    buf_rd   [LD_DEPTH];
  logic [31:0]   buf_data [LD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, drain, push, pop, core_grant;
  logic [31:0]   core_data;

  assign full       = (count == CW'(LD_DEPTH));
  assign empty      = (count == '0);
  assign ld_ready   = rst_n & ~full;
  assign core_stall = rst_n & core_wr_en & (full | drain);
  assign core_grant = core_wr_en & ~core_stall;
  assign pop        = rst_n & ~empty & ~core_grant;
  assign push       = ld_valid & ld_ready;

  always_comb begin
    core_data = alu_out;
    case (core_sel)
      2'b01:   core_data = pc_o + 32'd4;
      2'b10:   core_data = lui_imme;
      default: core_data = alu_out;
    endcase
  end

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_rd[wr_ptr]   <= ld_rd;
      buf_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (core_grant) begin
      rf_we    <= (core_rd != 5'd0);
      rf_waddr <= core_rd;
      rf_wdata <= core_data;
    end else if (pop) begin
      rf_we    <= (buf_rd[rd_ptr] != 5'd0);
      rf_waddr <= buf_rd[rd_ptr];
      rf_wdata <= buf_data[rd_ptr];
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef WB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {ST_CORE, ST_DRAIN} state_t;
  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_CORE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // The limit is checked on the next count so DRAIN lines up with the counter reaching it.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    if (pop || empty)
      starve_cnt_nxt = '0;
    else if (core_grant)
      starve_cnt_nxt = starve_cnt + 1'b1;
    case (state)
      ST_CORE:  if (starve_cnt_nxt == SW'(STARVE_LIMIT)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop) state_nxt = ST_CORE;
      default:  state_nxt = ST_CORE;
    endcase
  end

  assign drain = (state == ST_DRAIN);
`else
  assign drain = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
  localparam int LD_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n, core_wr_en, ld_valid, ld_ready, core_stall, rf_we;
  logic [4:0]  core_rd, ld_rd, rf_waddr;
  logic [1:0]  core_sel;
  logic [31:0] alu_out, pc_o, lui_imme, ld_data, rf_wdata;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.LD_DEPTH(LD_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .core_wr_en(core_wr_en), .core_rd(core_rd), .core_sel(core_sel),
    .alu_out(alu_out), .pc_o(pc_o), .lui_imme(lui_imme), .ld_valid(ld_valid), .ld_rd(ld_rd),
    .ld_data(ld_data), .ld_ready(ld_ready), .core_stall(core_stall), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ld_t;
  ld_t  wq[$];
  int   m_cnt = 0;
  bit   m_drain = 0;
  logic exp_ready, exp_stall, exp_we;
  logic [4:0]  exp_waddr = '0;
  logic [31:0] exp_wdata = '0;
  logic obs_ready, obs_stall;

  // Reference: one arbitration decision per cycle from the rules, using the current inputs.
  task automatic model_step();
    int  occ;
    bit  granted, popped;
    ld_t e;
    if (!rst_n) begin
      exp_ready = 0; exp_stall = 0; exp_we = 0; exp_waddr = '0; exp_wdata = '0;
      wq.delete(); m_cnt = 0; m_drain = 0;
      return;
    end
    occ = wq.size();
    granted = 0; popped = 0;
    exp_ready = (occ < LD_DEPTH);
    exp_stall = core_wr_en && (occ == LD_DEPTH || m_drain);
    exp_we = 0;
    if (core_wr_en && !exp_stall) begin
      granted = 1;
      exp_waddr = core_rd;
      exp_wdata = (core_sel == 2'b01) ? pc_o + 32'd4 : (core_sel == 2'b10) ? lui_imme : alu_out;
      exp_we = (core_rd != 0);
    end else if (occ > 0) begin
      e = wq.pop_front();
      popped = 1;
      exp_waddr = e.rd; exp_wdata = e.data; exp_we = (e.rd != 0);
    end
    if (ld_valid && exp_ready) begin
      e.rd = ld_rd; e.data = ld_data;
      wq.push_back(e);
    end
`ifdef WB_STARVE_EN
    if (popped || occ == 0) m_cnt = 0;
    else if (granted) m_cnt++;
    if (popped) m_drain = 0;
    if (m_cnt == STARVE_LIMIT) m_drain = 1;
`endif
  endtask

  task automatic tick();
    #1;
    obs_ready = ld_ready;
    obs_stall = core_stall;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic en, input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu);
    core_wr_en = en; core_rd = rd; core_sel = sel; alu_out = alu;
  endtask

  task automatic set_ld(input logic vld, input logic [4:0] rd, input logic [31:0] data);
    ld_valid = vld; ld_rd = rd; ld_data = data;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_core(1, 5'd3, 2'b00, 32'h1111); set_ld(1, 5'd4, 32'h2222);
    tick(); tick();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b expected 0", obs_ready); end
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL reset_core_stall: got %b expected 0", obs_stall); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr: got %0d expected 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata: got %h expected 0", rf_wdata); end
    rst_n = 1;
    set_core(0, 5'd0, 2'b00, 32'h0); set_ld(0, 5'd0, 32'h0);
    tick();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ld_ready: got %b expected 1", obs_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL post_reset_rf_we: got %b expected 0", rf_we); end
  endtask

  task automatic test_core_only();
    logic [1:0]  sels [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    logic [31:0] pcs  [5] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'hFFFF_FFFC};
    logic [31:0] want [5] = '{32'h1234_5678, 32'h104, 32'hABCD_0000, 32'h1234_5678, 32'h0};
    lui_imme = 32'hABCD_0000;
    for (int i = 0; i < 5; i++) begin
      pc_o = pcs[i];
      set_core(1, 5'(5 + i), sels[i], 32'h1234_5678);
      tick();
      checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL core_stall[%0d]: got %b expected 0", i, obs_stall); end
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(5 + i) || rf_wdata !== want[i])
        begin errors++; $display("FAIL core_write[%0d]: got we=%b a=%0d d=%h expected we=1 a=%0d d=%h", i, rf_we, rf_waddr, rf_wdata, 5 + i, want[i]); end
    end
    set_core(0, 5'd0, 2'b00, 32'h0);
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL core_idle_we: got %b expected 0", rf_we); end
  endtask

  task automatic test_idle_drain();
    set_ld(1, 5'd7, 32'hDEAD_BEEF);
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL drain_early_we: got %b expected 0", rf_we); end
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL drain_ready0: got %b expected 1", obs_ready); end
    set_ld(0, 5'd0, 32'h0);
    tick();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL drain_ready1: got %b expected 1", obs_ready); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL drain_write: got we=%b a=%0d d=%h expected we=1 a=7 d=deadbeef", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_full();
    set_core(1, 5'd3, 2'b00, 32'h11); set_ld(1, 5'd9, 32'hA1);
    tick();
    set_core(1, 5'd4, 2'b00, 32'h22); set_ld(1, 5'd10, 32'hA2);
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4) begin errors++; $display("FAIL full_core2: got we=%b a=%0d expected we=1 a=4", rf_we, rf_waddr); end
    set_core(1, 5'd5, 2'b00, 32'h33); set_ld(0, 5'd0, 32'h0);
    tick();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL full_ld_ready: got %b expected 0", obs_ready); end
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b expected 1", obs_stall); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hA1)
      begin errors++; $display("FAIL full_pop: got we=%b a=%0d d=%h expected we=1 a=9 d=a1", rf_we, rf_waddr, rf_wdata); end
    tick();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL full_resume_stall: got %b expected 0", obs_stall); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h33)
      begin errors++; $display("FAIL full_resume: got we=%b a=%0d d=%h expected we=1 a=5 d=33", rf_we, rf_waddr, rf_wdata); end
    set_core(0, 5'd0, 2'b00, 32'h0);
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hA2)
      begin errors++; $display("FAIL full_second_pop: got we=%b a=%0d d=%h expected we=1 a=10 d=a2", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_reg0();
    for (int i = 0; i < 4; i++) begin
      set_core(i < 2, 5'd0, 2'b00, 32'h55); set_ld(i < 2, 5'd0, 32'h66);
      tick();
      if (i == 2) begin
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL reg0_full: got %b expected 0", obs_ready); end
      end
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reg0_we[%0d]: got %b expected 0", i, rf_we); end
    end
    for (int i = 0; i < 2; i++) begin
      set_core(1, 5'd1, 2'b00, 32'h77); set_ld(1, 5'd2, 32'h88);
      tick();
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL reg0_empty_after[%0d]: got %b expected 1", i, obs_ready); end
    end
    set_core(0, 5'd0, 2'b00, 32'h0); set_ld(0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rf_we !== exp_we || (exp_we && rf_waddr !== exp_waddr))
        begin errors++; $display("FAIL reg0_drain[%0d]: got we=%b a=%0d expected we=%b a=%0d", i, rf_we, rf_waddr, exp_we, exp_waddr); end
    end
  endtask

  task automatic test_starve();
    int stall_at = -1;
    set_core(1, 5'd1, 2'b00, 32'h100); set_ld(1, 5'd8, 32'h88);
    tick();
    set_ld(0, 5'd0, 32'h0);
    for (int i = 1; i < 8; i++) begin
      set_core(1, 5'(i + 1), 2'b00, 32'(i));
      tick();
      if (obs_stall === 1'b1 && stall_at < 0) stall_at = i;
      checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL starve_stall[%0d]: got %b expected %b", i, obs_stall, exp_stall); end
      checks++; if (rf_we !== exp_we || (exp_we && (rf_waddr !== exp_waddr || rf_wdata !== exp_wdata)))
        begin errors++; $display("FAIL starve_write[%0d]: got we=%b a=%0d d=%h expected we=%b a=%0d d=%h", i, rf_we, rf_waddr, rf_wdata, exp_we, exp_waddr, exp_wdata); end
    end
    set_core(0, 5'd0, 2'b00, 32'h0);
    tick();
`ifdef WB_STARVE_EN
    checks++; if (stall_at !== 5) begin errors++; $display("FAIL starve_stall_cycle: got %0d expected 5", stall_at); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL starve_idle_we: got %b expected 0", rf_we); end
`else
    checks++; if (stall_at !== -1) begin errors++; $display("FAIL priority_stall_cycle: got %0d expected -1", stall_at); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h88)
      begin errors++; $display("FAIL priority_idle_drain: got we=%b a=%0d d=%h expected we=1 a=8 d=88", rf_we, rf_waddr, rf_wdata); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!(core_wr_en && obs_stall)) begin
        core_wr_en = ($urandom_range(0, 9) < 6);
        core_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
        core_sel   = 2'($urandom);
        alu_out    = $urandom; pc_o = $urandom; lui_imme = $urandom;
      end
      if (!(ld_valid && !obs_ready)) begin
        ld_valid = $urandom_range(0, 1);
        ld_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
        ld_data  = $urandom;
      end
      tick();
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, obs_ready, exp_ready); end
      checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, obs_stall, exp_stall); end
      checks++; if (rf_we !== exp_we || (exp_we && (rf_waddr !== exp_waddr || rf_wdata !== exp_wdata)))
        begin errors++; $display("FAIL rand_write[%0d]: got we=%b a=%0d d=%h expected we=%b a=%0d d=%h", i, rf_we, rf_waddr, rf_wdata, exp_we, exp_waddr, exp_wdata); end
    end
  endtask

  task automatic test_reset_mid();
    set_core(0, 5'd0, 2'b00, 32'h0); set_ld(0, 5'd0, 32'h0);
    tick(); tick(); tick();
    set_core(1, 5'd3, 2'b00, 32'h11); set_ld(1, 5'd12, 32'hC1);
    tick();
    set_ld(1, 5'd13, 32'hC2);
    tick();
    set_core(0, 5'd0, 2'b00, 32'h0); set_ld(0, 5'd0, 32'h0);
    rst_n = 0;
    tick();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", obs_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b expected 0", rf_we); end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL midrst_post_ready[%0d]: got %b expected 1", i, obs_ready); end
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL midrst_post_we[%0d]: got %b expected 0", i, rf_we); end
    end
  endtask

  initial begin
    rst_n = 0; pc_o = '0; lui_imme = '0;
    set_core(0, 5'd0, 2'b00, 32'h0); set_ld(0, 5'd0, 32'h0);
    obs_ready = 0; obs_stall = 0;
    test_reset();
    test_core_only();
    test_idle_drain();
    test_full();
    test_reg0();
    test_starve();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter LD_DEPTH, default 2: load-return buffer depth in entries, power of two, at least 2.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive core grants before a forced drain; used only with WB_STARVE_EN.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 core_wr_en  in  1  core requests a register-file write this cycle.
REQ-006 core_rd  in  5  core destination register.
REQ-007 core_sel  in  2  core source select: 00 ALU, 01 PC+4, 10 LUI immediate, 11 ALU.
REQ-008 alu_out, pc_o, lui_imme  in  32 each  core source operands.
REQ-009 ld_valid  in  1  load unit presents return data.
REQ-010 ld_rd  in  5  load destination register.
REQ-011 ld_data  in  32  load return data.
REQ-012 ld_ready  out  1  buffer can accept a load return this cycle.
REQ-013 core_stall  out  1  core write not accepted; core holds its request.
REQ-014 rf_we, rf_waddr[4:0], rf_wdata[31:0]  out  register-file write port, registered.

Function
REQ-015 Core write data SHALL be alu_out for core_sel 00/11, pc_o+4 (modulo 2^32) for 01, lui_imme for 10.
REQ-016 ld_ready SHALL equal NOT buffer-full; a load is pushed when ld_valid AND ld_ready; no push-through when full.
REQ-017 Buffer SHALL be FIFO; entries SHALL write the register file in arrival order.
REQ-018 Each cycle at most one grant: core if core_wr_en AND NOT core_stall; otherwise the FIFO head if the FIFO is non-empty; otherwise none.
REQ-019 core_stall SHALL be asserted, combinationally, when core_wr_en AND (FIFO full OR forced drain is active).
REQ-020 When core_stall is asserted, the FIFO head SHALL pop that cycle.
REQ-021 Granted write SHALL appear on rf_we/rf_waddr/rf_wdata on the next rising edge (latency 1); rf_we deasserted otherwise.
REQ-022 A grant to register 0 SHALL consume the request or pop the entry but hold rf_we at 0.
REQ-023 Simultaneous push and pop SHALL keep occupancy unchanged; pushing into an empty FIFO SHALL make that entry eligible no earlier than the next cycle.
REQ-024 Arbiter states: CORE (normal priority) and DRAIN (forced pop); without WB_STARVE_EN the state stays CORE.
REQ-025 Pointers SHALL wrap modulo LD_DEPTH; occupancy SHALL never exceed LD_DEPTH or underflow.

Reset
REQ-026 While rst_n is low at a clock edge, state SHALL be cleared: FIFO empty, pointers 0, state CORE, starve counter 0, rf_we 0, rf_waddr 0, rf_wdata 0.
REQ-027 While rst_n is low, ld_ready SHALL be 0 and core_stall SHALL be 0.
REQ-028 Reset mid-operation SHALL discard buffered loads without writing them; no partial write SHALL issue on the first post-reset cycle.

Configuration
REQ-029 Macro WB_STARVE_EN SHALL compile in a starvation counter, incremented on each core grant while the FIFO is non-empty and cleared on each pop or when the FIFO is empty.
REQ-030 With WB_STARVE_EN, a counter value of STARVE_LIMIT SHALL enter DRAIN, forcing one pop with core_stall asserted, then return to CORE with counter 0.
REQ-031 Without WB_STARVE_EN, the core SHALL have strict priority; loads drain only on idle or full cycles, and no counter logic SHALL exist.

Verification
REQ-032 Core-only: core_sel=01, pc_o=0x100, core_rd=5 -> next cycle rf_we=1, waddr=5, wdata=0x104.
REQ-033 Idle drain: one load (rd=7, data=0xDEADBEEF) with core idle -> written two cycles after push, ld_ready stays 1.
REQ-034 Full: LD_DEPTH=2, two loads pushed and core writing every cycle -> ld_ready=0, core_stall=1, head popped, then the core resumes with its held request.
REQ-035 Register 0: core_rd=0 and load rd=0 -> rf_we never 1; FIFO occupancy returns to 0.
REQ-036 WB_STARVE_EN, STARVE_LIMIT=4, one load pending, continuous core writes -> 4 core grants, 1 stall cycle pops the load, then core grants continue.
REQ-037 Reset with 2 loads buffered -> after release, no load write issues and ld_ready=1.
